// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with a per-entry pending scoreboard and a
// one-entry-per-cycle clear sweep. Define REGFILE_BYPASS_EN for same-cycle write forwarding.
module regfile_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NUM_RD   = 2,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_pend,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    output logic                     wr_ack,
    input  logic                     rsv_en,
    input  logic [ADDR_W-1:0]        rsv_addr,
    input  logic                     clr_start,
    output logic                     busy
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic              wr_commit;
    logic              rsv_commit;

    assign busy       = (state == CLEAR);
    assign wr_ack     = wr_en & ~busy;
    assign wr_commit  = wr_ack & ~(ZERO_REG && (wr_addr == '0));
    assign rsv_commit = rsv_en & ~busy & ~(ZERO_REG && (rsv_addr == '0));

    // NOTE: the array is reset with the rest of the state because reads must return zero the moment rst_n falls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            pend  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_commit) begin
                        mem[wr_addr]  <= wr_data;
                        pend[wr_addr] <= 1'b0;
                    end
                    // NOTE: the later non-blocking assignment to the same bit wins, so a reserve overrides a same-edge write-back.
                    if (rsv_commit) pend[rsv_addr] <= 1'b1;
                    if (clr_start) begin
                        state <= CLEAR;
                        cnt   <= '0;
                    end
                end
                CLEAR: begin
                    mem[cnt]  <= '0;
                    pend[cnt] <= 1'b0;
                    cnt       <= cnt + ADDR_W'(1);
                    if (cnt == ADDR_W'(DEPTH - 1)) state <= IDLE;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit_zero;
        logic [DATA_W-1:0] d;
        logic              pd;

        assign ra       = rd_addr[p*ADDR_W +: ADDR_W];
        assign hit_zero = ZERO_REG && (ra == '0);

        // NOTE: every output gets a default before any conditional override, so no latch is inferred.
        always_comb begin
            d  = hit_zero ? '0 : mem[ra];
            pd = ~hit_zero & pend[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_commit && (ra == wr_addr)) begin
                d  = wr_data;
                pd = rsv_commit && (rsv_addr == wr_addr);
            end
`endif
        end

        assign rd_data[p*DATA_W +: DATA_W] = d;
        assign rd_pend[p]                  = pd;
    end
endmodule
